// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state counter plus opcode decode into the datapath control word.
// Latency: controls are combinational from the current state; state advances once per clock.
// Backpressure: none; prog parks the machine in IDLE. Define SAP1_JUMP_EN to add JMP/JC/JZ.
module sap1_control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] t_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic pc_load;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_sub;
        logic alu_out;
        logic flags_load;
        logic out_load;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   is_arith;

    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        case (state)
            S_IDLE: state_nxt = S_T1;
            S_T1: begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
                state_nxt     = S_T2;
            end
            S_T2: begin
                ctrl.pc_inc = 1'b1;
                state_nxt   = S_T3;
            end
            S_T3: begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_load = 1'b1;
                state_nxt    = S_T4;
            end
            S_T4: begin
                // Unknown opcodes fall through as NOP and refetch.
                state_nxt = S_T1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl.ir_out   = 1'b1;
                        ctrl.mar_load = 1'b1;
                        state_nxt     = S_T5;
                    end
                    OP_OUT: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                    OP_HLT: state_nxt = S_HALT;
`ifdef SAP1_JUMP_EN
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = zero_flag;
                    end
`endif
                    default: state_nxt = S_T1;
                endcase
            end
            S_T5: begin
                state_nxt = S_T1;
                if (opcode == OP_LDA) begin
                    ctrl.ram_out = 1'b1;
                    ctrl.a_load  = 1'b1;
                end else if (is_arith) begin
                    ctrl.ram_out = 1'b1;
                    ctrl.b_load  = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                    state_nxt    = S_T6;
                end
            end
            S_T6: begin
                state_nxt = S_T1;
                if (is_arith) begin
                    ctrl.alu_out    = 1'b1;
                    ctrl.a_load     = 1'b1;
                    ctrl.flags_load = 1'b1;
                    ctrl.alu_sub    = (opcode == OP_SUB);
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        // Programming mode aborts any instruction, HALT included.
        if (prog) begin
            state_nxt = S_IDLE;
        end
    end

`ifndef SAP1_JUMP_EN
    logic unused_flags;
    assign unused_flags = carry_flag ^ zero_flag ^ (opcode == OP_JMP)
                        ^ (opcode == OP_JC) ^ (opcode == OP_JZ);
`endif

    assign pc_inc     = ctrl.pc_inc;
    assign pc_out     = ctrl.pc_out;
    assign pc_load    = ctrl.pc_load;
    assign mar_load   = ctrl.mar_load;
    assign ram_out    = ctrl.ram_out;
    assign ir_load    = ctrl.ir_load;
    assign ir_out     = ctrl.ir_out;
    assign a_load     = ctrl.a_load;
    assign a_out      = ctrl.a_out;
    assign b_load     = ctrl.b_load;
    assign alu_sub    = ctrl.alu_sub;
    assign alu_out    = ctrl.alu_out;
    assign flags_load = ctrl.flags_load;
    assign out_load   = ctrl.out_load;
    assign halted     = (state == S_HALT);
    assign t_state    = state;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Bench for sap1_control_sequencer: directed walk through the instruction set, then a random
// opcode/flag/prog/reset stream compared each cycle against a microprogram-table reference model.
module tb_sap1_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       prog;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic       pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_sub, alu_out, flags_load, out_load;
    logic       halted;
    logic [2:0] t_state;

    sap1_control_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .prog       (prog),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .pc_inc     (pc_inc),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .a_load     (a_load),
        .a_out      (a_out),
        .b_load     (b_load),
        .alu_sub    (alu_sub),
        .alu_out    (alu_out),
        .flags_load (flags_load),
        .out_load   (out_load),
        .halted     (halted),
        .t_state    (t_state)
    );

    always #5 clk = ~clk;

    // Control word bit positions, MSB first: pc_inc .. out_load.
    localparam logic [13:0] C_PC_INC   = 14'h2000;
    localparam logic [13:0] C_PC_OUT   = 14'h1000;
    localparam logic [13:0] C_PC_LOAD  = 14'h0800;
    localparam logic [13:0] C_MAR_LOAD = 14'h0400;
    localparam logic [13:0] C_RAM_OUT  = 14'h0200;
    localparam logic [13:0] C_IR_LOAD  = 14'h0100;
    localparam logic [13:0] C_IR_OUT   = 14'h0080;
    localparam logic [13:0] C_A_LOAD   = 14'h0040;
    localparam logic [13:0] C_A_OUT    = 14'h0020;
    localparam logic [13:0] C_B_LOAD   = 14'h0010;
    localparam logic [13:0] C_ALU_SUB  = 14'h0008;
    localparam logic [13:0] C_ALU_OUT  = 14'h0004;
    localparam logic [13:0] C_FLAGS    = 14'h0002;
    localparam logic [13:0] C_OUT_LOAD = 14'h0001;

    logic [13:0] obs_ctrl;
    assign obs_ctrl = {pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
                       a_load, a_out, b_load, alu_sub, alu_out, flags_load, out_load};

    int n_pass  = 0;
    int n_total = 0;
    int m_state = 0;   // model: 0 idle, 1..6 step within instruction, 7 halted

    function automatic bit jumps_enabled();
`ifdef SAP1_JUMP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_jump(logic [3:0] op);
        return jumps_enabled() && (op == 4'b0110 || op == 4'b0111 || op == 4'b1000);
    endfunction

    function automatic int instr_len(logic [3:0] op);
        if (op == 4'b0000) return 5;
        if (op == 4'b0001 || op == 4'b0010) return 6;
        return 4;
    endfunction

    // Microprogram table: control word for step n (1-based) of an instruction.
    function automatic logic [13:0] micro(int n, logic [3:0] op, logic c, logic z);
        logic [13:0] sub;
        sub = (op == 4'b0010) ? C_ALU_SUB : 14'h0;
        if (n == 1) return C_PC_OUT | C_MAR_LOAD;
        if (n == 2) return C_PC_INC;
        if (n == 3) return C_RAM_OUT | C_IR_LOAD;
        if (n > instr_len(op)) return 14'h0;
        if (op == 4'b0000) return (n == 4) ? (C_IR_OUT | C_MAR_LOAD) : (C_RAM_OUT | C_A_LOAD);
        if (op == 4'b0001 || op == 4'b0010) begin
            if (n == 4) return C_IR_OUT | C_MAR_LOAD;
            if (n == 5) return C_RAM_OUT | C_B_LOAD | sub;
            return C_ALU_OUT | C_A_LOAD | C_FLAGS | sub;
        end
        if (op == 4'b1110) return C_A_OUT | C_OUT_LOAD;
        if (is_jump(op)) begin
            if (op == 4'b0110) return C_IR_OUT | C_PC_LOAD;
            if (op == 4'b0111) return C_IR_OUT | (c ? C_PC_LOAD : 14'h0);
            return C_IR_OUT | (z ? C_PC_LOAD : 14'h0);
        end
        return 14'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Check outputs against the model for the current cycle, then advance one clock.
    task automatic cycle();
        logic [13:0] exp_ctrl;
        int          nxt;
        #1;
        exp_ctrl = (m_state >= 1 && m_state <= 6) ? micro(m_state, opcode, carry_flag, zero_flag) : 14'h0;
        check("t_state", 32'(t_state), m_state);
        check("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
        check("halted", 32'(halted), 32'(m_state == 7));
        check("bus_single_driver", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 1);
        check("inc_and_load", 32'(pc_inc & pc_load), 0);
        if (reset || prog) nxt = 0;
        else if (m_state == 0) nxt = 1;
        else if (m_state == 7) nxt = 7;
        else if (m_state == 4 && opcode == 4'b1111) nxt = 7;
        else if (m_state < instr_len(opcode)) nxt = m_state + 1;
        else nxt = 1;
        @(posedge clk);
        m_state = nxt;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; prog = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        @(posedge clk);
        @(negedge clk);
        repeat (3) cycle();
        check("reset_state", 32'(t_state), 0);
        check("reset_ctrl", 32'(obs_ctrl), 0);
        reset = 1'b0;
        cycle();
        check("first_t1", 32'(t_state), 1);
        check("first_t1_ctrl", 32'(obs_ctrl), 32'(C_PC_OUT | C_MAR_LOAD));

        // ADD then SUB: six states each, arithmetic controls in T5/T6.
        opcode = 4'b0001;
        repeat (4) cycle();
        check("add_t5", 32'(obs_ctrl), 32'(C_RAM_OUT | C_B_LOAD));
        cycle();
        check("add_t6", 32'(obs_ctrl), 32'(C_ALU_OUT | C_A_LOAD | C_FLAGS));
        cycle();
        check("add_back_t1", 32'(t_state), 1);
        opcode = 4'b0010;
        repeat (4) cycle();
        check("sub_t5", 32'(obs_ctrl), 32'(C_RAM_OUT | C_B_LOAD | C_ALU_SUB));
        cycle();
        check("sub_t6", 32'(obs_ctrl), 32'(C_ALU_OUT | C_A_LOAD | C_FLAGS | C_ALU_SUB));
        cycle();

        // LDA (5), OUT (4), HLT (4) then parked.
        opcode = 4'b0000;
        repeat (5) cycle();
        check("lda_len", 32'(t_state), 1);
        opcode = 4'b1110;
        repeat (3) cycle();
        check("out_t4", 32'(obs_ctrl), 32'(C_A_OUT | C_OUT_LOAD));
        cycle();
        check("out_len", 32'(t_state), 1);
        opcode = 4'b1111;
        repeat (4) cycle();
        check("hlt_state", 32'(t_state), 7);
        check("hlt_flag", 32'(halted), 1);
        repeat (20) cycle();
        check("hlt_holds", 32'(t_state), 7);
        prog = 1'b1;
        cycle();
        prog = 1'b0;
        check("prog_idle", 32'(t_state), 0);
        cycle();
        check("prog_resume_t1", 32'(t_state), 1);

        // prog in T5 of ADD aborts without the T6 write-back.
        opcode = 4'b0001;
        repeat (4) cycle();
        check("abort_at_t5", 32'(t_state), 5);
        prog = 1'b1;
        cycle();
        check("abort_idle", 32'(t_state), 0);
        check("abort_no_a_load", 32'(obs_ctrl), 0);
        prog = 1'b0;
        cycle();
        check("abort_resume", 32'(t_state), 1);

        // Conditional jump, or NOP when jumps are compiled out.
        opcode = 4'b0111;
        carry_flag = 1'b1;
        repeat (3) cycle();
        check("jc_taken", 32'(pc_load), 32'(jumps_enabled()));
        cycle();
        carry_flag = 1'b0;
        repeat (3) cycle();
        check("jc_not_taken", 32'(pc_load), 0);
        cycle();
        opcode = 4'b0110;
        repeat (3) cycle();
        check("jmp_t4", 32'(pc_load), 32'(jumps_enabled()));
        cycle();
        check("jmp_len", 32'(t_state), 1);

        // Random stream; opcode only changes outside the execute phase, as the IR would.
        for (int i = 0; i < 10000; i++) begin
            if (m_state <= 3 || m_state == 7) opcode = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom);
            zero_flag  = 1'($urandom);
            reset      = ($urandom_range(0, 255) == 0);
            prog       = (m_state == 7) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
